// File: rtl/cherry_pkg.sv
// ============================================================================
// cherry_pkg : shared instruction types and the instruction-queue entry format
// Rev 1.0
// ============================================================================
`default_nettype none

package cherry_pkg;

    localparam int ADDR_W     = 18;
    localparam int PAYLOAD_W  = 14;
    // Copy-count field is sized for LOG_SUPERSCALAR_WIDTH up to 7.
    localparam int COPY_CNT_W = 8;

    typedef enum logic [1:0] {
        INSTR_TYPE_LOAD_STORE = 2'd0,
        INSTR_TYPE_RAM        = 2'd1,
        INSTR_TYPE_ARITHMETIC = 2'd2,
        INSTR_TYPE_LOOP       = 2'd3
    } instr_type_t;

    typedef struct packed {
        instr_type_t             instr_type;
        logic [PAYLOAD_W-1:0]    payload;
        logic [ADDR_W-1:0]       cache_addr;
        logic [ADDR_W-1:0]       main_mem_addr;
        logic [ADDR_W-1:0]       d_cache_addr;
        logic [ADDR_W-1:0]       d_main_mem_addr;
        logic [COPY_CNT_W-1:0]   copy_count;
    } queue_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : pointer/count FIFO with combinational front read, async reset
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_queue.sv
// ============================================================================
// instruction_queue : buffers control-unit pushes and expands each into copies
// Optional INSTR_QUEUE_STATS_EN adds issue/stall counters.   Rev 1.0
// ============================================================================
`default_nettype none

module instruction_queue
    import cherry_pkg::*;
#(
    parameter int DEPTH                 = 16,
    parameter int LOG_SUPERSCALAR_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             queue_we,
    input  logic [1:0]                       queue_instr_type,
    input  logic [13:0]                      queue_arith_instr,
    input  logic [8:0]                       queue_ram_instr,
    input  logic [9:0]                       queue_ld_st_instr,
    input  logic [ADDR_W-1:0]                cache_addr,
    input  logic [ADDR_W-1:0]                main_mem_addr,
    input  logic [ADDR_W-1:0]                d_cache_addr,
    input  logic [ADDR_W-1:0]                d_main_mem_addr,
    input  logic [LOG_SUPERSCALAR_WIDTH:0]   queue_copy_count,
    output logic                             queue_full,
    output logic                             queue_overflow,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [1:0]                       issue_instr_type,
    output logic [13:0]                      issue_arith_instr,
    output logic [8:0]                       issue_ram_instr,
    output logic [9:0]                       issue_ld_st_instr,
    output logic [ADDR_W-1:0]                issue_cache_addr,
    output logic [ADDR_W-1:0]                issue_main_mem_addr,
    output logic [LOG_SUPERSCALAR_WIDTH-1:0] issue_copy_index,
    output logic                             issue_last
`ifdef INSTR_QUEUE_STATS_EN
    ,
    output logic [31:0]                      stat_issued,
    output logic [31:0]                      stat_stall
`endif
);

    localparam int LSW = LOG_SUPERSCALAR_WIDTH;
    localparam int CW  = LSW + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ISSUE = 1'b1
    } head_state_t;

    head_state_t          r_state, w_state_next;
    queue_entry_t         w_in_entry, w_fifo_front, w_src;
    logic                 w_fifo_empty, w_fifo_push, w_fifo_pop;
    logic                 w_push_acc, w_src_avail, w_fire, w_last, w_load_head;
    logic [CW-1:0]        w_src_copies;
    logic                 r_overflow;

    instr_type_t          r_type;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [ADDR_W-1:0]    r_cache, r_main, r_dcache, r_dmain;
    logic [CW-1:0]        r_copies;
    logic [LSW-1:0]       r_idx;

    always_comb begin
        w_in_entry                 = '0;
        w_in_entry.instr_type      = instr_type_t'(queue_instr_type);
        w_in_entry.cache_addr      = cache_addr;
        w_in_entry.main_mem_addr   = main_mem_addr;
        w_in_entry.d_cache_addr    = d_cache_addr;
        w_in_entry.d_main_mem_addr = d_main_mem_addr;
        w_in_entry.copy_count      = COPY_CNT_W'(queue_copy_count);
        case (instr_type_t'(queue_instr_type))
            INSTR_TYPE_ARITHMETIC: w_in_entry.payload = queue_arith_instr;
            INSTR_TYPE_RAM:        w_in_entry.payload = {5'd0, queue_ram_instr};
            INSTR_TYPE_LOAD_STORE: w_in_entry.payload = {4'd0, queue_ld_st_instr};
            default:               w_in_entry.payload = '0;
        endcase
    end

    assign w_push_acc   = queue_we && !queue_full &&
                          (instr_type_t'(queue_instr_type) != INSTR_TYPE_LOOP);
    assign issue_valid  = (r_state == ST_ISSUE);
    assign w_fire       = issue_valid && issue_ready;
    assign w_last       = (({1'b0, r_idx} + CW'(1)) == r_copies);
    assign w_load_head  = (r_state == ST_EMPTY) || (w_fire && w_last);
    assign w_src_avail  = !w_fifo_empty || w_push_acc;
    // Stored entries always go first; the incoming push only bypasses an empty FIFO.
    assign w_src        = w_fifo_empty ? w_in_entry : w_fifo_front;
    assign w_src_copies = (w_src.copy_count == '0) ? CW'(1) : CW'(w_src.copy_count);
    assign w_fifo_pop   = w_load_head && !w_fifo_empty;
    assign w_fifo_push  = w_push_acc && !(w_load_head && w_fifo_empty);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(queue_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .din   (w_in_entry),
        .dout  (w_fifo_front),
        .full  (queue_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_src_avail) w_state_next = ST_ISSUE;
            ST_ISSUE: if (w_fire && w_last && !w_src_avail) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_type    <= INSTR_TYPE_LOAD_STORE;
            r_payload <= '0;
            r_cache   <= '0;
            r_main    <= '0;
            r_dcache  <= '0;
            r_dmain   <= '0;
            r_copies  <= '0;
            r_idx     <= '0;
        end else if (w_load_head) begin
            if (w_src_avail) begin
                r_type    <= w_src.instr_type;
                r_payload <= w_src.payload;
                r_cache   <= w_src.cache_addr;
                r_main    <= w_src.main_mem_addr;
                r_dcache  <= w_src.d_cache_addr;
                r_dmain   <= w_src.d_main_mem_addr;
                r_copies  <= w_src_copies;
                r_idx     <= '0;
            end
        end else if (w_fire) begin
            r_idx <= r_idx + 1'b1;
            if (r_type != INSTR_TYPE_ARITHMETIC) begin
                r_cache <= r_cache + r_dcache;
                r_main  <= r_main + r_dmain;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (queue_we && queue_full)
            r_overflow <= 1'b1;
    end

    assign queue_overflow      = r_overflow;
    assign issue_instr_type    = issue_valid ? r_type : 2'd0;
    assign issue_arith_instr   = (issue_valid && r_type == INSTR_TYPE_ARITHMETIC) ? r_payload : '0;
    assign issue_ram_instr     = (issue_valid && r_type == INSTR_TYPE_RAM) ? r_payload[8:0] : '0;
    assign issue_ld_st_instr   = (issue_valid && r_type == INSTR_TYPE_LOAD_STORE) ? r_payload[9:0] : '0;
    assign issue_cache_addr    = issue_valid ? r_cache : '0;
    assign issue_main_mem_addr = issue_valid ? r_main : '0;
    assign issue_copy_index    = issue_valid ? r_idx : '0;
    assign issue_last          = issue_valid && w_last;

`ifdef INSTR_QUEUE_STATS_EN
    logic [31:0] r_stat_issued, r_stat_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_fire && (r_stat_issued != '1))
                r_stat_issued <= r_stat_issued + 1'b1;
            if (issue_valid && !issue_ready && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_queue.sv
// ============================================================================
// tb_instruction_queue : scoreboard bench for instruction_queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instruction_queue;

    localparam int DEPTH = 16;
    localparam int LSW   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        queue_we;
    logic [1:0]  queue_instr_type;
    logic [13:0] queue_arith_instr;
    logic [8:0]  queue_ram_instr;
    logic [9:0]  queue_ld_st_instr;
    logic [17:0] cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr;
    logic [LSW:0] queue_copy_count;
    logic        queue_full, queue_overflow, issue_valid, issue_ready, issue_last;
    logic [1:0]  issue_instr_type;
    logic [13:0] issue_arith_instr;
    logic [8:0]  issue_ram_instr;
    logic [9:0]  issue_ld_st_instr;
    logic [17:0] issue_cache_addr, issue_main_mem_addr;
    logic [LSW-1:0] issue_copy_index;
`ifdef INSTR_QUEUE_STATS_EN
    logic [31:0] stat_issued, stat_stall;
`endif

    instruction_queue #(.DEPTH(DEPTH), .LOG_SUPERSCALAR_WIDTH(LSW)) dut (
        .clk(clk), .reset(reset), .queue_we(queue_we), .queue_instr_type(queue_instr_type),
        .queue_arith_instr(queue_arith_instr), .queue_ram_instr(queue_ram_instr),
        .queue_ld_st_instr(queue_ld_st_instr), .cache_addr(cache_addr),
        .main_mem_addr(main_mem_addr), .d_cache_addr(d_cache_addr),
        .d_main_mem_addr(d_main_mem_addr), .queue_copy_count(queue_copy_count),
        .queue_full(queue_full), .queue_overflow(queue_overflow),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr_type(issue_instr_type), .issue_arith_instr(issue_arith_instr),
        .issue_ram_instr(issue_ram_instr), .issue_ld_st_instr(issue_ld_st_instr),
        .issue_cache_addr(issue_cache_addr), .issue_main_mem_addr(issue_main_mem_addr),
        .issue_copy_index(issue_copy_index), .issue_last(issue_last)
`ifdef INSTR_QUEUE_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  itype;
        logic [13:0] arith;
        logic [8:0]  ram;
        logic [9:0]  ldst;
        logic [17:0] cache;
        logic [17:0] main;
        logic [LSW-1:0] idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   issued_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every handshake must match the oldest expected copy.
    always @(negedge clk) begin
        if (!reset && issue_valid && issue_ready) begin
            issued_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("type",  {30'd0, issue_instr_type}, {30'd0, e.itype});
                check("arith", {18'd0, issue_arith_instr}, {18'd0, e.arith});
                check("ram",   {23'd0, issue_ram_instr}, {23'd0, e.ram});
                check("ldst",  {22'd0, issue_ld_st_instr}, {22'd0, e.ldst});
                check("cache", {14'd0, issue_cache_addr}, {14'd0, e.cache});
                check("main",  {14'd0, issue_main_mem_addr}, {14'd0, e.main});
                check("idx",   {29'd0, issue_copy_index}, {29'd0, e.idx});
                check("last",  {31'd0, issue_last}, {31'd0, e.last});
            end
        end
    end

    // Drive one push for one cycle; caller sits just after a rising edge.
    task automatic push(input logic [1:0] t, input logic [13:0] p, input logic [17:0] ca,
                        input logic [17:0] ma, input logic [17:0] dca, input logic [17:0] dma,
                        input logic [LSW:0] cc, input bit stored);
        int n;
        queue_we          = 1'b1;
        queue_instr_type  = t;
        queue_arith_instr = p;
        queue_ram_instr   = p[8:0] ^ 9'h1A5;
        queue_ld_st_instr = p[9:0] ^ 10'h2C3;
        cache_addr        = ca;
        main_mem_addr     = ma;
        d_cache_addr      = dca;
        d_main_mem_addr   = dma;
        queue_copy_count  = cc;
        if (stored) begin
            n = (cc == 0) ? 1 : int'(cc);
            for (int i = 0; i < n; i++) begin
                exp_t e;
                e.itype = t;
                e.arith = (t == 2'd2) ? p : 14'd0;
                e.ram   = (t == 2'd1) ? (p[8:0] ^ 9'h1A5) : 9'd0;
                e.ldst  = (t == 2'd0) ? (p[9:0] ^ 10'h2C3) : 10'd0;
                e.cache = (t == 2'd2) ? ca : 18'(ca + 18'(i) * dca);
                e.main  = (t == 2'd2) ? ma : 18'(ma + 18'(i) * dma);
                e.idx   = LSW'(i);
                e.last  = (i == n - 1);
                exp_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        queue_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || issue_valid) && i < 500) begin
            @(posedge clk); #1;
            i++;
        end
        @(negedge clk);
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        int base;
        reset = 1'b1; queue_we = 1'b0; queue_instr_type = '0; queue_arith_instr = '0;
        queue_ram_instr = '0; queue_ld_st_instr = '0; cache_addr = '0; main_mem_addr = '0;
        d_cache_addr = '0; d_main_mem_addr = '0; queue_copy_count = '0; issue_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, issue_valid}, 32'd0);
        check("rst_full", {31'd0, queue_full}, 32'd0);
        check("rst_ovf", {31'd0, queue_overflow}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: idle LD_ST, 3 copies back-to-back after one cycle of latency
        base = issued_cnt;
        push(2'd0, 14'h0155, 18'd100, 18'd2000, 18'd4, 18'd8, 4'd3, 1'b1);
        check("lat_valid", {31'd0, issue_valid}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("t1_count", issued_cnt - base, 32'd3);
        wait_drain();

        // 2: RAM with copies=0 then a wrapping 2-copy variant
        push(2'd1, 14'h00AB, 18'h00010, 18'h3FFFE, 18'd1, 18'd4, 4'd0, 1'b1);
        wait_drain();
        push(2'd1, 14'h0033, 18'h00010, 18'h3FFFE, 18'd1, 18'd4, 4'd2, 1'b1);
        wait_drain();

        // 3: fill while stalled: head + DEPTH stored, one more dropped
        issue_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            push(2'(i % 3), 14'(i * 7 + 1), 18'(i * 16), 18'(i * 32), 18'd1, 18'd1, 4'd1, 1'b1);
        check("not_full_yet", {31'd0, queue_full}, 32'd0);
        push(2'd0, 14'h0AAA, 18'h01000, 18'h02000, 18'd1, 18'd1, 4'd1, 1'b1);
        check("full", {31'd0, queue_full}, 32'd1);
        check("ovf_before", {31'd0, queue_overflow}, 32'd0);
        push(2'd2, 14'h3FFF, 18'h03000, 18'h04000, 18'd1, 18'd1, 4'd1, 1'b0);
        check("ovf_set", {31'd0, queue_overflow}, 32'd1);
        issue_ready = 1'b1;
        wait_drain();

        // 4: LOOP discarded silently; ARITHMETIC keeps addresses
        do_reset();
        push(2'd3, 14'h1234, 18'd5, 18'd6, 18'd1, 18'd1, 4'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("loop_valid", {31'd0, issue_valid}, 32'd0);
        check("loop_ovf", {31'd0, queue_overflow}, 32'd0);
        push(2'd2, 14'h2ABC, 18'd500, 18'd600, 18'd10, 18'd20, 4'd2, 1'b1);
        wait_drain();

        // 5: stall 5 cycles on copy 1 of 4; outputs must hold
        do_reset();
        push(2'd0, 14'h0077, 18'd1000, 18'd3000, 18'd12, 18'd24, 4'd4, 1'b1);
        @(posedge clk); #1;
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_idx", {29'd0, issue_copy_index}, 32'd1);
            check("stall_cache", {14'd0, issue_cache_addr}, 32'd1012);
            @(posedge clk); #1;
        end
        issue_ready = 1'b1;
        wait_drain();
`ifdef INSTR_QUEUE_STATS_EN
        check("stat_stall", stat_stall, 32'd5);
        check("stat_issued", stat_issued, 32'd4);
`endif

        // 6: async reset mid-expansion
        do_reset();
        push(2'd1, 14'h0011, 18'd40, 18'd80, 18'd1, 18'd2, 4'd4, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst_async_valid", {31'd0, issue_valid}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        base = issued_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_valid", {31'd0, issue_valid}, 32'd0);
        check("post_rst_full", {31'd0, queue_full}, 32'd0);
        check("post_rst_issues", issued_cnt - base, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
